// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end: word width, fetch FSM states
// and helpers for the cache address split.
package cpu_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_LOOKUP = 2'd0,
        ST_REFILL = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // Byte-offset bits within a line, and line-index bits.
    function automatic int off_bits(input int line_words);
        return 2 + $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int cache_lines);
        return $clog2(cache_lines);
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Instruction queue between the fetch cache and the decoder: power-of-2 FIFO
// holding {instruction, pc} pairs, cleared in one cycle on flush.
module ifetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_ins,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [XLEN-1:0] head_ins,
    output logic [XLEN-1:0] head_pc
);

    localparam int AW = $clog2(DEPTH);

    // The extra MSB tells a full queue apart from an empty one.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            ins_mem[wr_ptr[AW-1:0]] <= push_ins;
            pc_mem[wr_ptr[AW-1:0]]  <= push_pc;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_ins = empty ? '0 : ins_mem[rd_ptr[AW-1:0]];
    assign head_pc  = empty ? '0 : pc_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ifetch_line_cache.sv
// Instruction fetch unit: direct-mapped I-cache with whole-line byte-serial
// refill over the shared 8-bit bus, feeding the decoder through ifetch_queue.
module ifetch_line_cache
    import cpu_defs::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int CACHE_LINES = 16,
    parameter int LINE_WORDS  = 4,
    parameter int ADDR_BITS   = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    input  logic        mem_busy_in,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic        dec_valid_out,
    input  logic        dec_ready_in,
    output logic [31:0] dec_ins_out,
    output logic [31:0] dec_pc_out
);

    localparam int OFF        = off_bits(LINE_WORDS);
    localparam int IDX        = idx_bits(CACHE_LINES);
    localparam int TAG_W      = ADDR_BITS - OFF - IDX;
    localparam int LINE_BYTES = 4 * LINE_WORDS;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int FW         = IDX + OFF - 2;
    localparam int CNT_W      = $clog2(LINE_BYTES) + 1;

    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0] LAST_ADDR_CNT = CNT_W'(LINE_BYTES - 1);
    localparam logic [XLEN-1:0]  LINE_MASK     = ~XLEN'(LINE_BYTES - 1);

    fetch_state_t state;
    fetch_state_t next_state;

    logic [XLEN-1:0]        pc;
    logic [CNT_W-1:0]       cnt;
    logic [IDX-1:0]         fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic [LINE_W-9:0]      line_buf;
    logic [LINE_W-1:0]      new_line;
    logic [CACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]       tag_arr  [CACHE_LINES];
    logic [XLEN-1:0]        data_arr [CACHE_LINES*LINE_WORDS];

    logic [IDX-1:0]   pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [FW-1:0]    pc_word;
    logic             hit;
    logic             pop;
    logic             can_push;
    logic             q_full;
    logic             q_empty;
    logic             do_push;
    logic             start_refill;
    logic             refill_step;
    logic             install;

    assign pc_idx   = pc[OFF+IDX-1:OFF];
    assign pc_tag   = pc[ADDR_BITS-1:OFF+IDX];
    assign pc_word  = pc[OFF+IDX-1:2];
    assign hit      = line_valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign pop      = rdy_in && !q_empty && dec_ready_in;
    // A pop in the same cycle frees the slot a full queue needs.
    assign can_push = !q_full || pop;
    assign new_line = {mem_din, line_buf};

    always_ff @(posedge clk_in) begin
        if (rst_in)      state <= ST_LOOKUP;
        else if (rdy_in) state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush_in) begin
            next_state = ST_LOOKUP;
        end else begin
            case (state)
                ST_LOOKUP: if (start_refill) next_state = ST_REFILL;
                ST_REFILL: begin
                    if (mem_busy_in)  next_state = ST_BUBBLE;
                    else if (install) next_state = ST_LOOKUP;
                end
                ST_BUBBLE: if (!mem_busy_in) next_state = ST_LOOKUP;
                default:   next_state = ST_LOOKUP;
            endcase
        end
    end

    always_comb begin
        do_push      = 1'b0;
        start_refill = 1'b0;
        refill_step  = 1'b0;
        install      = 1'b0;
        if (rdy_in && !flush_in) begin
            case (state)
                ST_LOOKUP: begin
                    if (can_push) begin
                        if (hit)               do_push      = 1'b1;
                        else if (!mem_busy_in) start_refill = 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (!mem_busy_in) begin
                        refill_step = 1'b1;
                        install     = (cnt == LAST_CNT);
                    end
                end
                default: ;
            endcase
        end
    end

    // cnt k means address base+k is on the bus and byte k-1 is on mem_din.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc         <= '0;
            mem_a      <= '0;
            cnt        <= '0;
            line_valid <= '0;
        end else if (rdy_in) begin
            if (flush_in)     pc <= flush_pc_in & ~32'h3;
            else if (do_push) pc <= pc + 32'd4;
            if (start_refill) begin
                mem_a <= pc & LINE_MASK;
                cnt   <= '0;
            end
            if (refill_step) begin
                cnt <= cnt + 1'b1;
                if (cnt < LAST_ADDR_CNT) mem_a <= mem_a + 32'd1;
                if (install) line_valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (start_refill) begin
            fill_idx <= pc_idx;
            fill_tag <= pc_tag;
        end
        if (refill_step && cnt != '0) line_buf <= {mem_din, line_buf[LINE_W-9:8]};
        if (install) begin
            tag_arr[fill_idx] <= fill_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_arr[FW'(int'(fill_idx) * LINE_WORDS + w)] <= new_line[w*32 +: 32];
            end
        end
    end

    ifetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk_in),
        .rst      (rst_in),
        .flush    (rdy_in && flush_in),
        .push     (do_push),
        .push_ins (data_arr[pc_word]),
        .push_pc  (pc),
        .pop      (pop),
        .full     (q_full),
        .empty    (q_empty),
        .head_ins (dec_ins_out),
        .head_pc  (dec_pc_out)
    );

    assign dec_valid_out = !q_empty;
    assign mem_wr        = 1'b0;

endmodule

// File: doc/ifetch_line_cache.md
Name: ifetch_line_cache

Overview:
Second-generation instruction fetch unit. It has a parametrised direct-mapped I-cache with multi-word lines, whole-line byte-serial refill from the shared 8-bit memory bus, and a power-of-2 instruction queue. The queue feeds the decoder over a valid/ready handshake. The unit sits between the memory arbiter (shared with the LSB) and the decoder; ROB redirects it via flush.

Parameters:
QUEUE_DEPTH, 8, instruction queue entries (power of 2, >=2)
CACHE_LINES, 16, number of direct-mapped lines (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=1)
ADDR_BITS, 17, low address bits decoded (tag = pc[ADDR_BITS-1 : OFF+IDX])

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when 0 all state holds
flush_in  in  1  redirect from ROB
flush_pc_in  in  32  redirect target
mem_busy_in  in  1  LSB owns memory bus this cycle
mem_din  in  8  memory read byte (1-cycle latency after address)
mem_a  out  32  memory byte address
mem_wr  out  1  always 0 (read)
dec_valid_out  out  1  queue head valid
dec_ready_in  in  1  decoder accepts head
dec_ins_out  out  32  head instruction word (little-endian assembled)
dec_pc_out  out  32  address of that instruction (not pc+4)

Behaviour:
- Clock/reset: one clock clk_in; rst_in synchronous, active-high, and takes priority over rdy_in. Derived widths: OFF = 2+log2(LINE_WORDS), IDX = log2(CACHE_LINES).
- Reset: pc=0, queue empty, all line valid bits 0, state=LOOKUP, mem_a=0, mem_wr=0, dec_valid_out=0, dec_ins_out=0, dec_pc_out=0.
- rdy_in=0 (no reset): nothing changes.
- FSM states:
  - LOOKUP:
    - queue full: hold pc.
    - hit (valid[idx] && tag match): push {word, pc} this cycle, pc += 4. Throughput is 1 instr/cycle.
    - miss: go to REFILL with line base = pc & ~(4*LINE_WORDS-1).
  - REFILL:
    - Issues byte addresses base..base+4*LINE_WORDS-1, one per cycle.
    - Byte k is captured from mem_din in the cycle after address k.
    - Refill latency is 4*LINE_WORDS+1 cycles.
    - On the last capture, write data/tag and set valid. Return to LOOKUP; the next cycle hits.
  - BUBBLE: one idle cycle after mem_busy_in falls, then LOOKUP (restart refill if the line is still missing).
- Bus yield: any cycle with mem_busy_in=1 aborts refill. Nothing is written and captured bytes are discarded. Go to BUBBLE once busy drops; do not drive a new mem_a while busy. Cache hits continue during busy (no bus use).
- Flush (priority over everything except reset):
  - queue emptied, pc = {flush_pc_in[31:2],2'b00}, refill aborted with line not installed, state = LOOKUP.
  - valid bits are preserved.
  - dec_valid_out = 0 next cycle; a handshake in the flush cycle is still consumed.
- Queue:
  - dec_valid_out = !empty.
  - Pop on dec_valid_out && dec_ready_in.
  - Push and pop in the same cycle are legal when full or empty as applicable (no lost or duplicated entry).
  - Pointers are log2(QUEUE_DEPTH)+1 bits wide; full when MSBs differ and the rest are equal.
- Refill completing while the queue is full installs the line only; the push happens on a later LOOKUP.
- pc arithmetic wraps mod 2^32. Address bits >= ADDR_BITS are ignored for tag compare.
- Word assembly: ins = {b3,b2,b1,b0}, where b0 is at the lowest address.

Decomposition:
- Shared header cpu_defs:
  - XLEN=32
  - fetch FSM state encodings (LOOKUP/REFILL/BUBBLE)
  - NOP constant
  - helper localparams OFF/IDX widths
- One sub-module: ifetch_queue (parametrised FIFO: push/pop/flush, full/empty, data+pc).
- Cache arrays and FSM stay in ifetch_line_cache.

Test Plan:
- Cold start, program 0x00..0x0F in memory, dec_ready_in=1, LINE_WORDS=4:
  - mem_a steps 0x0..0xF on 16 consecutive cycles.
  - First dec_valid_out arrives 17-18 cycles after reset release, with dec_pc_out=0x0.
  - pcs 0x0,0x4,0x8,0xC follow back-to-back.
- Loop jump back to 0x0 via flush_pc_in=0x0 after the line is cached: no memory addresses are issued; 4 instructions are delivered on 4 consecutive cycles.
- mem_busy_in=1 for 3 cycles at byte 5 of a refill:
  - mem_a is not advanced while busy.
  - After 1 bubble cycle, refill restarts at the line base.
  - Delivered word at pc 0x4 equals memory contents (no stale bytes).
- flush_in with flush_pc_in=0x103 mid-refill:
  - dec_valid_out=0 next cycle; refill restarts at 0x100.
  - Old line valid bit stays 0.
  - First delivered dec_pc_out=0x100.
- dec_ready_in=0 with QUEUE_DEPTH=8:
  - Exactly 8 entries accepted, then pc holds.
  - Raising dec_ready_in drains pcs in order with no gap or duplicate.
- Aliasing: fetch 0x0 then 0x10000 (same index, different tag, ADDR_BITS=17):
  - Second access misses and refills.
  - Re-fetching 0x0 misses again.
